// File: rtl/osm_statistic_counter.sv
// ---------------------------------------------------------------------------
// osm_statistic_counter
//
// Purpose:
//   Per-port packet and async-FIFO event counter bank. Counts start-of-frame
//   events on eight RX and eight TX data-valid strobes, plus RX/TX async-FIFO
//   overflow and underflow pulses, in twenty free-running 32-bit counters.
//   The counters are read combinationally by the management register stage.
//
// Ports:
//   i_clk                         system clock, rising edge
//   i_rst_n                       synchronous active-low reset
//   iv_rx_data_valid[7:0]         per-port RX frame valid (high for whole frame)
//   iv_tx_data_valid[7:0]         per-port TX frame valid (high for whole frame)
//   i_rxasyncfifo_overflow        single-cycle event pulse
//   i_rxasyncfifo_underflow       single-cycle event pulse
//   i_txasyncfifo_overflow        single-cycle event pulse
//   i_txasyncfifo_underflow       single-cycle event pulse
//   i_clear                       clear all counters (active high, per cycle)
//   ov_*asyncfifo_*_cnt[31:0]     FIFO event counts
//   ov_inpkt_cnt_p0..p7[31:0]     RX frame counts per port
//   ov_outpkt_cnt_p0..p7[31:0]    TX frame counts per port
//
// Configuration macro:
//   OSM_CNT_SATURATE_EN  defined   -> counters hold at 0xFFFFFFFF
//                        undefined -> counters wrap modulo 2^32
//
// Handshake: none. All inputs are sampled every rising edge; all outputs are
// registered and stable between edges.
// ---------------------------------------------------------------------------
module osm_statistic_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  iv_rx_data_valid,
    input  logic [7:0]  iv_tx_data_valid,
    input  logic        i_rxasyncfifo_overflow,
    input  logic        i_rxasyncfifo_underflow,
    input  logic        i_txasyncfifo_overflow,
    input  logic        i_txasyncfifo_underflow,
    input  logic        i_clear,
    output logic [31:0] ov_rxasyncfifo_overflow_cnt,
    output logic [31:0] ov_rxasyncfifo_underflow_cnt,
    output logic [31:0] ov_txasyncfifo_overflow_cnt,
    output logic [31:0] ov_txasyncfifo_underflow_cnt,
    output logic [31:0] ov_inpkt_cnt_p0,
    output logic [31:0] ov_inpkt_cnt_p1,
    output logic [31:0] ov_inpkt_cnt_p2,
    output logic [31:0] ov_inpkt_cnt_p3,
    output logic [31:0] ov_inpkt_cnt_p4,
    output logic [31:0] ov_inpkt_cnt_p5,
    output logic [31:0] ov_inpkt_cnt_p6,
    output logic [31:0] ov_inpkt_cnt_p7,
    output logic [31:0] ov_outpkt_cnt_p0,
    output logic [31:0] ov_outpkt_cnt_p1,
    output logic [31:0] ov_outpkt_cnt_p2,
    output logic [31:0] ov_outpkt_cnt_p3,
    output logic [31:0] ov_outpkt_cnt_p4,
    output logic [31:0] ov_outpkt_cnt_p5,
    output logic [31:0] ov_outpkt_cnt_p6,
    output logic [31:0] ov_outpkt_cnt_p7
);

    // Previous-cycle valid, used for start-of-frame detection.
    logic [7:0]  rv_rx_prev_q, rv_rx_prev_d;
    logic [7:0]  rv_tx_prev_q, rv_tx_prev_d;

    logic [31:0] in_cnt_q  [8];
    logic [31:0] in_cnt_d  [8];
    logic [31:0] out_cnt_q [8];
    logic [31:0] out_cnt_d [8];

    logic [31:0] rx_ovf_cnt_q, rx_ovf_cnt_d;
    logic [31:0] rx_unf_cnt_q, rx_unf_cnt_d;
    logic [31:0] tx_ovf_cnt_q, tx_ovf_cnt_d;
    logic [31:0] tx_unf_cnt_q, tx_unf_cnt_d;

    logic [7:0]  rx_sof;
    logic [7:0]  tx_sof;

    assign rx_sof = iv_rx_data_valid & ~rv_rx_prev_q;
    assign tx_sof = iv_tx_data_valid & ~rv_tx_prev_q;

    // Next value of one counter for a single-bit increment request.
    function automatic logic [31:0] cnt_next(input logic [31:0] cur,
                                             input logic        inc);
`ifdef OSM_CNT_SATURATE_EN
        if (inc && (cur != 32'hFFFF_FFFF)) begin
            cnt_next = cur + 32'd1;
        end else begin
            cnt_next = cur;
        end
`else
        cnt_next = inc ? (cur + 32'd1) : cur;
`endif
    endfunction

    always_comb begin
        // prev tracks valid unconditionally, even while clearing, so a frame
        // whose start collides with clear is never counted later.
        rv_rx_prev_d = iv_rx_data_valid;
        rv_tx_prev_d = iv_tx_data_valid;

        for (int n = 0; n < 8; n++) begin
            in_cnt_d[n]  = in_cnt_q[n];
            out_cnt_d[n] = out_cnt_q[n];
        end
        rx_ovf_cnt_d = rx_ovf_cnt_q;
        rx_unf_cnt_d = rx_unf_cnt_q;
        tx_ovf_cnt_d = tx_ovf_cnt_q;
        tx_unf_cnt_d = tx_unf_cnt_q;

        if (i_clear) begin
            // Clear wins over any coincident event; those events are dropped.
            for (int n = 0; n < 8; n++) begin
                in_cnt_d[n]  = 32'd0;
                out_cnt_d[n] = 32'd0;
            end
            rx_ovf_cnt_d = 32'd0;
            rx_unf_cnt_d = 32'd0;
            tx_ovf_cnt_d = 32'd0;
            tx_unf_cnt_d = 32'd0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                in_cnt_d[n]  = cnt_next(in_cnt_q[n],  rx_sof[n]);
                out_cnt_d[n] = cnt_next(out_cnt_q[n], tx_sof[n]);
            end
            rx_ovf_cnt_d = cnt_next(rx_ovf_cnt_q, i_rxasyncfifo_overflow);
            rx_unf_cnt_d = cnt_next(rx_unf_cnt_q, i_rxasyncfifo_underflow);
            tx_ovf_cnt_d = cnt_next(tx_ovf_cnt_q, i_txasyncfifo_overflow);
            tx_unf_cnt_d = cnt_next(tx_unf_cnt_q, i_txasyncfifo_underflow);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // prev resets to ones so a frame in progress at reset release is
            // not mistaken for a new start of frame.
            rv_rx_prev_q <= 8'hFF;
            rv_tx_prev_q <= 8'hFF;
            for (int n = 0; n < 8; n++) begin
                in_cnt_q[n]  <= 32'd0;
                out_cnt_q[n] <= 32'd0;
            end
            rx_ovf_cnt_q <= 32'd0;
            rx_unf_cnt_q <= 32'd0;
            tx_ovf_cnt_q <= 32'd0;
            tx_unf_cnt_q <= 32'd0;
        end else begin
            rv_rx_prev_q <= rv_rx_prev_d;
            rv_tx_prev_q <= rv_tx_prev_d;
            for (int n = 0; n < 8; n++) begin
                in_cnt_q[n]  <= in_cnt_d[n];
                out_cnt_q[n] <= out_cnt_d[n];
            end
            rx_ovf_cnt_q <= rx_ovf_cnt_d;
            rx_unf_cnt_q <= rx_unf_cnt_d;
            tx_ovf_cnt_q <= tx_ovf_cnt_d;
            tx_unf_cnt_q <= tx_unf_cnt_d;
        end
    end

    assign ov_rxasyncfifo_overflow_cnt  = rx_ovf_cnt_q;
    assign ov_rxasyncfifo_underflow_cnt = rx_unf_cnt_q;
    assign ov_txasyncfifo_overflow_cnt  = tx_ovf_cnt_q;
    assign ov_txasyncfifo_underflow_cnt = tx_unf_cnt_q;

    assign ov_inpkt_cnt_p0  = in_cnt_q[0];
    assign ov_inpkt_cnt_p1  = in_cnt_q[1];
    assign ov_inpkt_cnt_p2  = in_cnt_q[2];
    assign ov_inpkt_cnt_p3  = in_cnt_q[3];
    assign ov_inpkt_cnt_p4  = in_cnt_q[4];
    assign ov_inpkt_cnt_p5  = in_cnt_q[5];
    assign ov_inpkt_cnt_p6  = in_cnt_q[6];
    assign ov_inpkt_cnt_p7  = in_cnt_q[7];

    assign ov_outpkt_cnt_p0 = out_cnt_q[0];
    assign ov_outpkt_cnt_p1 = out_cnt_q[1];
    assign ov_outpkt_cnt_p2 = out_cnt_q[2];
    assign ov_outpkt_cnt_p3 = out_cnt_q[3];
    assign ov_outpkt_cnt_p4 = out_cnt_q[4];
    assign ov_outpkt_cnt_p5 = out_cnt_q[5];
    assign ov_outpkt_cnt_p6 = out_cnt_q[6];
    assign ov_outpkt_cnt_p7 = out_cnt_q[7];

endmodule

// File: tb/tb_osm_statistic_counter.sv
// ---------------------------------------------------------------------------
// tb_osm_statistic_counter
//
// Directed scenarios followed by a randomized phase. A behavioural model
// keeps expected counts as plain integers: a frame is counted when a port's
// valid is seen high after having been seen low, FIFO events add one per
// high cycle, clear zeroes everything, reset zeroes everything and treats
// every port as already mid-frame. All twenty counters are compared after
// every clock edge, plus explicit checks against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_osm_statistic_counter;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [7:0]  rx_v;
    logic [7:0]  tx_v;
    logic        rx_ovf, rx_unf, tx_ovf, tx_unf;
    logic        clr;

    logic [31:0] in_cnt  [8];
    logic [31:0] out_cnt [8];
    logic [31:0] fifo_cnt [4];   // 0 rx_ovf, 1 rx_unf, 2 tx_ovf, 3 tx_unf

    osm_statistic_counter dut (
        .i_clk                        (clk),
        .i_rst_n                      (rst_n),
        .iv_rx_data_valid             (rx_v),
        .iv_tx_data_valid             (tx_v),
        .i_rxasyncfifo_overflow       (rx_ovf),
        .i_rxasyncfifo_underflow      (rx_unf),
        .i_txasyncfifo_overflow       (tx_ovf),
        .i_txasyncfifo_underflow      (tx_unf),
        .i_clear                      (clr),
        .ov_rxasyncfifo_overflow_cnt  (fifo_cnt[0]),
        .ov_rxasyncfifo_underflow_cnt (fifo_cnt[1]),
        .ov_txasyncfifo_overflow_cnt  (fifo_cnt[2]),
        .ov_txasyncfifo_underflow_cnt (fifo_cnt[3]),
        .ov_inpkt_cnt_p0              (in_cnt[0]),
        .ov_inpkt_cnt_p1              (in_cnt[1]),
        .ov_inpkt_cnt_p2              (in_cnt[2]),
        .ov_inpkt_cnt_p3              (in_cnt[3]),
        .ov_inpkt_cnt_p4              (in_cnt[4]),
        .ov_inpkt_cnt_p5              (in_cnt[5]),
        .ov_inpkt_cnt_p6              (in_cnt[6]),
        .ov_inpkt_cnt_p7              (in_cnt[7]),
        .ov_outpkt_cnt_p0             (out_cnt[0]),
        .ov_outpkt_cnt_p1             (out_cnt[1]),
        .ov_outpkt_cnt_p2             (out_cnt[2]),
        .ov_outpkt_cnt_p3             (out_cnt[3]),
        .ov_outpkt_cnt_p4             (out_cnt[4]),
        .ov_outpkt_cnt_p5             (out_cnt[5]),
        .ov_outpkt_cnt_p6             (out_cnt[6]),
        .ov_outpkt_cnt_p7             (out_cnt[7])
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_in   [8];
    logic [31:0] exp_out  [8];
    logic [31:0] exp_fifo [4];
    logic [7:0]  seen_rx;   // last valid vector the counter bank observed
    logic [7:0]  seen_tx;

    function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef OSM_CNT_SATURATE_EN
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
`else
        return v + 32'd1;
`endif
    endfunction

    task automatic model_edge();
        logic [3:0] ev;
        ev = {tx_unf, tx_ovf, rx_unf, rx_ovf};
        if (!rst_n) begin
            for (int n = 0; n < 8; n++) begin
                exp_in[n] = 0;
                exp_out[n] = 0;
            end
            for (int k = 0; k < 4; k++) exp_fifo[k] = 0;
            seen_rx = 8'hFF;
            seen_tx = 8'hFF;
        end else begin
            if (clr) begin
                for (int n = 0; n < 8; n++) begin
                    exp_in[n] = 0;
                    exp_out[n] = 0;
                end
                for (int k = 0; k < 4; k++) exp_fifo[k] = 0;
            end else begin
                for (int n = 0; n < 8; n++) begin
                    if (rx_v[n] && !seen_rx[n]) exp_in[n]  = bump(exp_in[n]);
                    if (tx_v[n] && !seen_tx[n]) exp_out[n] = bump(exp_out[n]);
                end
                for (int k = 0; k < 4; k++)
                    if (ev[k]) exp_fifo[k] = bump(exp_fifo[k]);
            end
            seen_rx = rx_v;
            seen_tx = tx_v;
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < 8; n++) begin
            check_val($sformatf("inpkt_p%0d", n), in_cnt[n], exp_in[n]);
            check_val($sformatf("outpkt_p%0d", n), out_cnt[n], exp_out[n]);
        end
        for (int k = 0; k < 4; k++)
            check_val($sformatf("fifo_%0d", k), fifo_cnt[k], exp_fifo[k]);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives inputs, lets one rising edge happen,
    // updates the model and compares just after the edge.
    task automatic step(input logic r, input logic [7:0] rv, input logic [7:0] tv,
                        input logic [3:0] ev, input logic c);
        rst_n  = r;
        rx_v   = rv;
        tx_v   = tv;
        rx_ovf = ev[0];
        rx_unf = ev[1];
        tx_ovf = ev[2];
        tx_unf = ev[3];
        clr    = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int n = 0; n < 8; n++) begin
            exp_in[n] = 0;
            exp_out[n] = 0;
        end
        for (int k = 0; k < 4; k++) exp_fifo[k] = 0;
        seen_rx = 8'hFF;
        seen_tx = 8'hFF;
        @(negedge clk);

        // Reset release with a frame already in progress on RX port 0.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h01, 8'h00, 4'h0, 1'b0);
        check_val("reset_inpkt_p0", in_cnt[0], 32'd0);
        check_val("reset_fifo0", fifo_cnt[0], 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 8'h00, 4'h0, 1'b0);
        check_val("held_frame_not_counted", in_cnt[0], 32'd0);
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check_val("before_new_frame", in_cnt[0], 32'd0);
        step(1'b1, 8'h01, 8'h00, 4'h0, 1'b0);
        check_val("new_frame_first_edge", in_cnt[0], 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h01, 8'h00, 4'h0, 1'b0);
        idle(2);
        check_val("new_frame_total", in_cnt[0], 32'd1);

        // All-port TX burst: 3 frames, 5 high / 2 low, all ports together.
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 8'hFF, 4'h0, 1'b0);
            for (int i = 0; i < 2; i++) step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        end
        for (int n = 0; n < 8; n++) begin
            check_val($sformatf("burst_outpkt_p%0d", n), out_cnt[n], 32'd3);
            check_val($sformatf("burst_inpkt_p%0d", n), in_cnt[n], 32'd0);
        end

        // FIFO event widths: 4-cycle pulse then a 1-cycle pulse.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 8'h00, 4'h8, 1'b0);
        idle(2);
        step(1'b1, 8'h00, 8'h00, 4'h8, 1'b0);
        idle(1);
        check_val("txunf_width", fifo_cnt[3], 32'd5);
        check_val("rxovf_quiet", fifo_cnt[0], 32'd0);
        check_val("rxunf_quiet", fifo_cnt[1], 32'd0);
        check_val("txovf_quiet", fifo_cnt[2], 32'd0);

        // Clear collision on port 3.
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b1);
        for (int f = 0; f < 7; f++) begin
            step(1'b1, 8'h08, 8'h00, 4'h0, 1'b0);
            step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        end
        check_val("p3_preclear", in_cnt[3], 32'd7);
        step(1'b1, 8'h08, 8'h00, 4'h0, 1'b1);
        check_val("p3_clear_edge", in_cnt[3], 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h08, 8'h00, 4'h0, 1'b0);
        check_val("p3_through_frame", in_cnt[3], 32'd0);
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1'b1, 8'h08, 8'h00, 4'h0, 1'b0);
        check_val("p3_next_frame", in_cnt[3], 32'd1);
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);

        // Minimum spacing on port 5, then a long held frame.
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h20, 8'h00, 4'h0, 1'b0);
            step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        end
        check_val("p5_toggle", in_cnt[5], 32'd3);
        for (int i = 0; i < 1000; i++) step(1'b1, 8'h20, 8'h00, 4'h0, 1'b0);
        check_val("p5_long_hold", in_cnt[5], 32'd4);
        step(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);

        // Wrap / saturate on the RX overflow counter.
        force dut.rx_ovf_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rx_ovf_cnt_q;
        exp_fifo[0] = 32'hFFFF_FFFE;
        step(1'b1, 8'h00, 8'h00, 4'h1, 1'b0);
        check_val("wrap_1", fifo_cnt[0], 32'hFFFF_FFFF);
        step(1'b1, 8'h00, 8'h00, 4'h1, 1'b0);
`ifdef OSM_CNT_SATURATE_EN
        check_val("sat_2", fifo_cnt[0], 32'hFFFF_FFFF);
`else
        check_val("wrap_2", fifo_cnt[0], 32'h0000_0000);
`endif
        step(1'b1, 8'h00, 8'h00, 4'h1, 1'b0);
`ifdef OSM_CNT_SATURATE_EN
        check_val("sat_3", fifo_cnt[0], 32'hFFFF_FFFF);
`else
        check_val("wrap_3", fifo_cnt[0], 32'h0000_0001);
`endif

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
